// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: operand width, register index type and the x0 index.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rv_dec5_32.sv
// 5-to-32 one-hot decoder with enable; output bit 0 never asserts so x0 is never targeted.
module rv_dec5_32 (
  input  logic        en,
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);
  import rv32i_pkg::*;

  always_comb begin
    onehot = '0;
    if (en && (reg_idx_t'(idx) != REG_ZERO)) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rv_regfile_sb.sv
// RV32I architectural register file with a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module rv_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_pend,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_pend,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            pend_any
);
  import rv32i_pkg::*;

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wb_en;
  logic [NREG-1:0] iss_set;

  rv_dec5_32 u_dec_wb  (.en(wb_valid),  .idx(wb_rd),  .onehot(wb_en));
  rv_dec5_32 u_dec_iss (.en(iss_valid), .idx(iss_rd), .onehot(iss_set));

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           regs[i] <= '0;
      else if (wb_en[i]) regs[i] <= wb_data;
    end
  end

  // Set beats clear on a same-cycle issue/writeback to one index; pend[0] stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~wb_en) | iss_set;
  end

  function automatic logic [XLEN-1:0] rd_sel(input reg_idx_t a);
    logic [XLEN-1:0] d;
    d = '0;
    for (int i = 1; i < NREG; i++)
      if (a == reg_idx_t'(i)) d = regs[i];
    return d;
  endfunction

  always_comb begin
    rs1_data = rd_sel(rs1_addr);
    rs2_data = rd_sel(rs2_addr);
    rs1_pend = pend[rs1_addr];
    rs2_pend = pend[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_valid && (wb_rd != REG_ZERO) && (rs1_addr == wb_rd)) begin
      rs1_data = wb_data;
      rs1_pend = iss_valid && (iss_rd == rs1_addr);
    end
    if (wb_valid && (wb_rd != REG_ZERO) && (rs2_addr == wb_rd)) begin
      rs2_data = wb_data;
      rs2_pend = iss_valid && (iss_rd == rs2_addr);
    end
`endif
  end

  assign pend_any = |pend;

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed self-checking bench for rv_regfile_sb.
module tb_rv_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, iss_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        rs1_pend, rs2_pend, iss_valid, wb_valid, pend_any;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rv_regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_pend(rs1_pend),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_pend(rs2_pend),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pend_any(pend_any)
  );

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0;
    wb_valid  = 1'b0; wb_rd  = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0; idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    n_total++; if (rs1_data !== 32'h0) $display("FAIL reset_rs1_data got %h want %h", rs1_data, 32'h0); else n_pass++;
    n_total++; if (pend_any !== 1'b0) $display("FAIL reset_pend_any got %b want 0", pend_any); else n_pass++;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    idle();
    n_total++; if (rs1_data !== 32'hDEADBEEF) $display("FAIL pre_reset_x5 got %h want %h", rs1_data, 32'hDEADBEEF); else n_pass++;
    n_total++; if (pend_any !== 1'b1) $display("FAIL pre_reset_pend_any got %b want 1", pend_any); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (rs1_data !== 32'h0) $display("FAIL async_reset_x5 got %h want %h", rs1_data, 32'h0); else n_pass++;
    n_total++; if (pend_any !== 1'b0) $display("FAIL async_reset_pend_any got %b want 0", pend_any); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic_write();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
    tick();
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    n_total++; if (rs1_data !== 32'h12345678) $display("FAIL basic_rs1 got %h want %h", rs1_data, 32'h12345678); else n_pass++;
    n_total++; if (rs2_data !== 32'h12345678) $display("FAIL basic_rs2 got %h want %h", rs2_data, 32'h12345678); else n_pass++;
    n_total++; if (rs1_pend !== 1'b0) $display("FAIL basic_unpended_wb got %b want 0", rs1_pend); else n_pass++;
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd7;
    tick();
    idle();
    #1;
    n_total++; if (rs1_data !== 32'h0) $display("FAIL x0_data got %h want %h", rs1_data, 32'h0); else n_pass++;
    n_total++; if (rs1_pend !== 1'b0) $display("FAIL x0_pend got %b want 0", rs1_pend); else n_pass++;
    n_total++; if (pend_any !== 1'b0) $display("FAIL x0_pend_any got %b want 0", pend_any); else n_pass++;
    n_total++; if (rs2_data !== 32'h12345678) $display("FAIL x0_wb_leak_x7 got %h want %h", rs2_data, 32'h12345678); else n_pass++;
  endtask

  task automatic test_scoreboard();
    rs1_addr = 5'd4; rs2_addr = 5'd3;
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    n_total++; if (rs2_pend !== 1'b1) $display("FAIL sb_set_pend got %b want 1", rs2_pend); else n_pass++;
    n_total++; if (pend_any !== 1'b1) $display("FAIL sb_set_pend_any got %b want 1", pend_any); else n_pass++;
    n_total++; if (rs1_pend !== 1'b0) $display("FAIL sb_other_pend got %b want 0", rs1_pend); else n_pass++;
    tick();
    n_total++; if (rs2_pend !== 1'b1) $display("FAIL sb_hold_pend got %b want 1", rs2_pend); else n_pass++;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h000000A5;
    tick();
    idle();
    n_total++; if (rs2_pend !== 1'b0) $display("FAIL sb_clr_pend got %b want 0", rs2_pend); else n_pass++;
    n_total++; if (rs2_data !== 32'hA5) $display("FAIL sb_clr_data got %h want %h", rs2_data, 32'hA5); else n_pass++;
    n_total++; if (pend_any !== 1'b0) $display("FAIL sb_clr_pend_any got %b want 0", pend_any); else n_pass++;
  endtask

  task automatic test_same_cycle();
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b1; iss_rd = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h11;
    tick();
    idle();
    n_total++; if (rs1_pend !== 1'b1) $display("FAIL same_cycle_pend got %b want 1", rs1_pend); else n_pass++;
    n_total++; if (rs1_data !== 32'h11) $display("FAIL same_cycle_data got %h want %h", rs1_data, 32'h11); else n_pass++;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h22;
    tick();
    idle();
    n_total++; if (rs2_pend !== 1'b0) $display("FAIL same_cycle_drain got %b want 0", rs2_pend); else n_pass++;
  endtask

  task automatic test_read_during_write();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h1;
    tick();
    rs1_addr = 5'd4; rs2_addr = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_total++; if (rs1_data !== 32'h2) $display("FAIL rdw_same_cycle got %h want %h", rs1_data, 32'h2); else n_pass++;
`else
    n_total++; if (rs1_data !== 32'h1) $display("FAIL rdw_same_cycle got %h want %h", rs1_data, 32'h1); else n_pass++;
`endif
    n_total++; if (rs2_data !== 32'h12345678) $display("FAIL rdw_other_port got %h want %h", rs2_data, 32'h12345678); else n_pass++;
    tick();
    idle();
    n_total++; if (rs1_data !== 32'h2) $display("FAIL rdw_after_edge got %h want %h", rs1_data, 32'h2); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1, exp2;
    for (int i = 1; i < 32; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'h01010101 * i;
      iss_valid = 1'b1; iss_rd = 5'(i);
      tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(32 - i);
      exp1 = 32'h01010101 * i;
      exp2 = 32'h01010101 * (32 - i);
      #1;
      n_total++; if (rs1_data !== exp1 || rs1_pend !== 1'b1) $display("FAIL b2b_rs1 x%0d got %h/%b want %h/1", i, rs1_data, rs1_pend, exp1); else n_pass++;
      n_total++; if (rs2_data !== exp2 || rs2_pend !== 1'b1) $display("FAIL b2b_rs2 x%0d got %h/%b want %h/1", 32 - i, rs2_data, rs2_pend, exp2); else n_pass++;
    end
    for (int i = 31; i >= 1; i--) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = ~(32'h01010101 * i);
      tick();
      n_total++; if (pend_any !== (i > 1)) $display("FAIL b2b_drain_pend_any after x%0d got %b want %b", i, pend_any, (i > 1)); else n_pass++;
    end
    idle();
    rs1_addr = 5'd17; rs2_addr = 5'd30;
    #1;
    n_total++; if (rs1_data !== ~(32'h01010101 * 17) || rs1_pend !== 1'b0) $display("FAIL b2b_final_x17 got %h/%b want %h/0", rs1_data, rs1_pend, ~(32'h01010101 * 17)); else n_pass++;
    n_total++; if (rs2_data !== ~(32'h01010101 * 30) || rs2_pend !== 1'b0) $display("FAIL b2b_final_x30 got %h/%b want %h/0", rs2_data, rs2_pend, ~(32'h01010101 * 30)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_x0();
    test_scoreboard();
    test_same_cycle();
    test_read_during_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
